// File: rtl/param_register_file.sv
// param_register_file: DEPTH x WIDTH general-purpose register bank.
// One synchronous write port, two combinational read ports, optional
// hard-wired zero register, optional write-to-read bypass, synchronous
// bulk clear and a registered flag for the previous cycle's illegal write.
module param_register_file #(
    parameter int WIDTH    = 20,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              w_err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             w_err_q;
    logic             w_err_d;
    logic             wr_in_range;
    logic             wr_to_zero;
    logic             wr_legal;

    // Classify the write attempted this cycle.
    always_comb begin
        wr_in_range = ({1'b0, waddr} < DEPTH_L);
        wr_to_zero  = (ZERO_REG != 0) && (waddr == '0);
        wr_legal    = w && wr_in_range && !wr_to_zero;
        w_err_d     = w && !wr_legal;
    end

    // Next register contents: clear beats write; register 0 stays zero when hard-wired.
    always_comb begin
        regs_d = regs_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_legal) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
        end
    end

    // Register bank and error flag, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            w_err_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            w_err_q <= w_err_d;
        end
    end

    assign w_err = w_err_q;

    // Read port A: stored value, optional same-cycle bypass, forced 0 in reset.
    always_comb begin
        rdata_a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((raddr_a == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                rdata_a = regs_q[i];
            end
        end
        if ((BYPASS != 0) && wr_legal && !clr && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
        if (!rst_n) begin
            rdata_a = '0;
        end
    end

    // Read port B: identical to port A, fully independent.
    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((raddr_b == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                rdata_b = regs_q[i];
            end
        end
        if ((BYPASS != 0) && wr_legal && !clr && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
        if (!rst_n) begin
            rdata_b = '0;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file: two instances share all inputs -- the default
// configuration (DEPTH 8, bypass on) and an alternate one (DEPTH 6, bypass
// off). A behavioural model of each predicts reads and w_err; predictions
// are queued when stimulus is driven and popped when outputs are sampled.
module tb_param_register_file;

    logic        clk;
    logic        rst_n;
    logic        w;
    logic [2:0]  waddr;
    logic [19:0] wdata;
    logic        clr;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [19:0] rdata_a, rdata_b, alt_rdata_a, alt_rdata_b;
    logic        w_err, alt_w_err;

    logic [19:0] exp_q[$];
    int          checks;
    int          errors;

    logic [19:0] m_dut [8];
    logic [19:0] m_alt [8];

    param_register_file #(.WIDTH(20), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .w(w), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .w_err(w_err)
    );

    param_register_file #(.WIDTH(20), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .w(w), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .rdata_a(alt_rdata_a), .raddr_b(raddr_b), .rdata_b(alt_rdata_b),
        .w_err(alt_w_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_legal(input int depth);
        return w && (int'(waddr) < depth) && (waddr != 3'd0);
    endfunction

    function automatic logic [19:0] model_read(input int alt, input logic [2:0] ra);
        int depth;
        depth = alt ? 6 : 8;
        if (!rst_n) return 20'd0;
        if (!alt && is_legal(depth) && !clr && ra == waddr) return wdata;
        if (int'(ra) >= depth || ra == 3'd0) return 20'd0;
        return alt ? m_alt[ra] : m_dut[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_dut[i] = 20'd0;
            m_alt[i] = 20'd0;
        end
    endtask

    task automatic push_reads();
        exp_q.push_back(model_read(0, raddr_a));
        exp_q.push_back(model_read(0, raddr_b));
        exp_q.push_back(model_read(1, raddr_a));
        exp_q.push_back(model_read(1, raddr_b));
    endtask

    task automatic pop_reads(input string ctx);
        check_eq($sformatf("%s dut_rd_a[%0d]", ctx, raddr_a), rdata_a, exp_q.pop_front());
        check_eq($sformatf("%s dut_rd_b[%0d]", ctx, raddr_b), rdata_b, exp_q.pop_front());
        check_eq($sformatf("%s alt_rd_a[%0d]", ctx, raddr_a), alt_rdata_a, exp_q.pop_front());
        check_eq($sformatf("%s alt_rd_b[%0d]", ctx, raddr_b), alt_rdata_b, exp_q.pop_front());
    endtask

    task automatic pop_errs(input string ctx);
        check_eq({ctx, " dut_w_err"}, {19'd0, w_err}, exp_q.pop_front());
        check_eq({ctx, " alt_w_err"}, {19'd0, alt_w_err}, exp_q.pop_front());
    endtask

    // driver: one full cycle, checks reads before the edge and w_err after it
    task automatic cycle(input logic iw, input logic [2:0] iwaddr, input logic [19:0] iwdata,
                         input logic iclr, input logic [2:0] ira, input logic [2:0] irb);
        logic leg_d, leg_a;
        @(negedge clk);
        w = iw; waddr = iwaddr; wdata = iwdata; clr = iclr;
        raddr_a = ira; raddr_b = irb;
        push_reads();
        #2;
        pop_reads("pre");
        @(posedge clk);
        leg_d = is_legal(8);
        leg_a = is_legal(6);
        exp_q.push_back({19'd0, w && !leg_d});
        exp_q.push_back({19'd0, w && !leg_a});
        if (clr) begin
            model_reset();
        end else begin
            if (leg_d) m_dut[waddr] = wdata;
            if (leg_a) m_alt[waddr] = wdata;
        end
        #1;
        pop_errs("post");
    endtask

    task automatic idle_read(input logic [2:0] ira, input logic [2:0] irb);
        cycle(1'b0, 3'd0, 20'd0, 1'b0, ira, irb);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; w = 1'b0; waddr = 3'd0; wdata = 20'd0; clr = 1'b0;
        raddr_a = 3'd3; raddr_b = 3'd5;
        model_reset();

        // reset state
        #12;
        push_reads();
        exp_q.push_back(20'd0);
        exp_q.push_back(20'd0);
        pop_reads("reset");
        pop_errs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // reset then write
        cycle(1'b1, 3'd3, 20'd45, 1'b0, 3'd3, 3'd5);
        idle_read(3'd3, 3'd5);

        // enable gating
        cycle(1'b1, 3'd2, 20'd54, 1'b0, 3'd1, 3'd2);
        cycle(1'b0, 3'd2, 20'd100, 1'b0, 3'd2, 3'd2);
        cycle(1'b0, 3'd2, 20'd100, 1'b0, 3'd2, 3'd3);
        idle_read(3'd2, 3'd2);

        // zero register and out-of-range addresses
        cycle(1'b1, 3'd0, 20'd101, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 3'd7, 20'd5, 1'b0, 3'd7, 3'd0);
        cycle(1'b1, 3'd6, 20'd66, 1'b0, 3'd6, 3'd7);
        idle_read(3'd6, 3'd0);
        cycle(1'b1, 3'd5, 20'hFFFFF, 1'b0, 3'd5, 3'd6);
        idle_read(3'd5, 3'd5);

        // bypass vs stored read
        cycle(1'b1, 3'd4, 20'd10, 1'b0, 3'd0, 3'd1);
        cycle(1'b1, 3'd4, 20'd105, 1'b0, 3'd4, 3'd4);
        idle_read(3'd4, 3'd4);

        // clear priority over write, bypass suppressed during clear
        cycle(1'b1, 3'd1, 20'd7, 1'b0, 3'd1, 3'd1);
        cycle(1'b1, 3'd2, 20'd8, 1'b0, 3'd1, 3'd2);
        cycle(1'b1, 3'd3, 20'd9, 1'b0, 3'd2, 3'd3);
        cycle(1'b1, 3'd1, 20'hFFFFF, 1'b1, 3'd1, 3'd2);
        idle_read(3'd1, 3'd3);
        idle_read(3'd2, 3'd4);
        cycle(1'b1, 3'd7, 20'd3, 1'b1, 3'd0, 3'd7);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 20'($urandom_range(0, 20'hFFFFF)),
                  $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // async reset pulse between edges
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, 3'(i), 20'(10 + i), 1'b0, 3'(i), 3'd0);
        end
        cycle(1'b1, 3'd0, 20'd1, 1'b0, 3'd3, 3'd5);
        @(negedge clk);
        w = 1'b1; waddr = 3'd3; wdata = 20'h12345; clr = 1'b0;
        raddr_a = 3'd3; raddr_b = 3'd5;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_reads();
        exp_q.push_back(20'd0);
        exp_q.push_back(20'd0);
        pop_reads("async");
        pop_errs("async");
        w = 1'b0;
        #2;
        rst_n = 1'b1;
        idle_read(3'd3, 3'd5);
        idle_read(3'd1, 3'd7);

        // reset held across an edge with a write pending
        @(negedge clk);
        w = 1'b1; waddr = 3'd1; wdata = 20'h55555; raddr_a = 3'd1; raddr_b = 3'd1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        push_reads();
        exp_q.push_back(20'd0);
        exp_q.push_back(20'd0);
        pop_reads("rst_edge");
        pop_errs("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        w = 1'b0;
        idle_read(3'd1, 3'd1);
        cycle(1'b1, 3'd1, 20'hABCDE, 1'b0, 3'd2, 3'd1);
        idle_read(3'd1, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the single fixed-width write-enabled register: a bank of DEPTH registers, each WIDTH bits wide.
- One synchronous write port, two combinational read ports, optional hard-wired zero register, optional write-to-read bypass, synchronous bulk clear, registered illegal-write flag.
- Sits in the CPU datapath as the general-purpose register bank between decode and the ALU.

Parameters:
WIDTH, 20, data width of every register and data port
DEPTH, 8, number of implemented registers (1..2**ADDR_W)
ADDR_W, 3, width of all address ports
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = a read of the address being written this cycle returns wdata; 0 = returns the stored value

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
w  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
clr  input  1  synchronous clear of all registers
raddr_a  input  ADDR_W  read port A address
rdata_a  output  WIDTH  read port A data (combinational)
raddr_b  input  ADDR_W  read port B address
rdata_b  output  WIDTH  read port B data (combinational)
w_err  output  1  registered flag: the previous cycle attempted an illegal write

Behaviour:
- Reset: rst_n low clears every register to 0 and w_err to 0 immediately, independent of clk. Both rdata outputs read 0 while reset is held. On release, the first active edge is the next rising clk.
- Legal write: w=1, waddr<DEPTH, and not (ZERO_REG=1 and waddr=0). A legal write stores wdata at the rising edge. Write latency is 1 cycle.
- Illegal write: w=1 and the write is not legal. Storage is unchanged. w_err=1 for exactly the following cycle.
- w_err update: at every edge, w_err takes the illegal-write condition of the cycle just ended. It is 0 after any cycle with w=0.
- Clear: clr=1 zeroes all registers at the edge.
  - clr has priority over w: a simultaneous write is discarded.
  - w_err is still evaluated normally during a clear.
- Read: rdata_x is the stored value at raddr_x, combinational, 0-cycle latency.
  - raddr_x>=DEPTH reads 0.
  - With ZERO_REG=1, raddr_x=0 always reads 0.
- Bypass (BYPASS=1): if a legal write is in progress, clr=0, and raddr_x=waddr, then rdata_x=wdata in the same cycle.
  - A clr=1 cycle disables bypass and reads show stored values.
  - With BYPASS=0, reads show the pre-edge stored value.
- Both read ports are independent and may address the same register.
- Reset asserted mid-write: the write is lost and the register stays 0.
- Width rule: wdata is stored unmodified; no sign or zero extension happens inside the block.

Test Plan:
- Reset then write: rst_n 0->1, w=1 waddr=3 wdata=20'd45. After the edge raddr_a=3 -> 45; raddr_b=5 -> 0; w_err=0.
- Enable gating: reg 2 holds 54; w=0 waddr=2 wdata=100 for two edges -> raddr_a=2 reads 54; w_err=0.
- Zero register and range (ZERO_REG=1, DEPTH=6, ADDR_W=3): w=1 waddr=0 wdata=101 -> reg 0 reads 0 and w_err=1 for one cycle. Then waddr=7 -> w_err=1, and raddr=7 reads 0. Then w=0 -> w_err=0.
- Bypass (BYPASS=1): reg 4=10; w=1 waddr=4 wdata=105 with raddr_a=raddr_b=4 -> both read 105 before the edge. Repeat with BYPASS=0 -> both read 10 before the edge and 105 after.
- Clear priority: regs 1..3 = 7,8,9; clr=1 with w=1 waddr=1 wdata=0xFFFFF -> all read 0 after the edge; bypass on raddr_a=1 reads 7 during the clr cycle.
- Async reset mid-operation: regs loaded with 11..17; drop rst_n for 3 ns between edges -> all rdata and w_err go to 0 immediately without a clock edge. Write raddr 1 = 0xABCDE after release -> reads 0xABCDE.
